// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: redirect inputs, instruction-memory handshake, decode-side buffer, counters.
// The master modport is the fetch unit; the slave modport is memory/decode/EX.
interface pc_fetch_unit_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ILEN      = 32,
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 trap_valid;
    logic [XLEN-1:0]      trap_pc;
    logic                 redirect_valid;
    logic [XLEN-1:0]      redirect_pc;
    logic                 fetch_req_valid;
    logic [XLEN-1:0]      fetch_req_addr;
    logic                 fetch_req_ready;
    logic                 fetch_rsp_valid;
    logic [ILEN-1:0]      fetch_rsp_data;
    logic                 if_valid;
    logic [XLEN-1:0]      if_pc;
    logic [ILEN-1:0]      if_instr;
    logic                 if_ready;
    logic                 misaligned;
    logic [CNT_WIDTH-1:0] fetch_count;

    modport master (
        input  trap_valid, trap_pc, redirect_valid, redirect_pc,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, if_ready,
        output fetch_req_valid, fetch_req_addr, if_valid, if_pc, if_instr,
        output misaligned, fetch_count
    );

    modport slave (
        output trap_valid, trap_pc, redirect_valid, redirect_pc,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, if_ready,
        input  fetch_req_valid, fetch_req_addr, if_valid, if_pc, if_instr,
        input  misaligned, fetch_count
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer with a one-entry
// decode buffer, trap/branch redirects (killing in-flight fetches) and a delivery counter.
module pc_fetch_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     ILEN         = 32,
    parameter int unsigned     INSTR_BYTES  = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     CNT_WIDTH    = 32
) (
    input  logic                clk,
    input  logic                reset,
    pc_fetch_unit_if.master     bus
);

    localparam logic [XLEN-1:0] PcStep    = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] AlignMask = ~XLEN'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

    state_e               state_q, state_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [XLEN-1:0]      if_pc_q, if_pc_d;
    logic [ILEN-1:0]      if_instr_q, if_instr_d;
    logic                 kill_q, kill_d;
    logic                 misaligned_q, misaligned_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic                 redir;
    logic [XLEN-1:0]      target;
    logic [XLEN-1:0]      target_aligned;

    // Trap wins over branch/jump redirect.
    assign redir          = bus.trap_valid | bus.redirect_valid;
    assign target         = bus.trap_valid ? bus.trap_pc : bus.redirect_pc;
    assign target_aligned = target & AlignMask;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        kill_d       = kill_q;
        count_d      = count_q;
        misaligned_d = redir && (target != target_aligned);

        unique case (state_q)
            StReq: begin
                if (bus.fetch_req_ready) begin
                    if_pc_d = pc_q;
                    state_d = StWait;
                    kill_d  = redir;
                end
            end
            StWait: begin
                if (bus.fetch_rsp_valid) begin
                    if (kill_q || redir) begin
                        kill_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        if_instr_d = bus.fetch_rsp_data;
                        pc_d       = if_pc_q + PcStep;
                        state_d    = StHold;
                    end
                end else if (redir) begin
                    kill_d = 1'b1;
                end
            end
            StHold: begin
                if (redir) begin
                    state_d = StReq;
                end else if (bus.if_ready) begin
                    state_d = StReq;
                    count_d = count_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = StReq;
        endcase

        // A redirect always owns the next PC, overriding the sequential increment.
        if (redir) begin
            pc_d = target_aligned;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StReq;
            pc_q         <= RESET_VECTOR;
            if_pc_q      <= '0;
            if_instr_q   <= '0;
            kill_q       <= 1'b0;
            misaligned_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            kill_q       <= kill_d;
            misaligned_q <= misaligned_d;
            count_q      <= count_d;
        end
    end

    assign bus.fetch_req_valid = (state_q == StReq);
    assign bus.fetch_req_addr  = pc_q;
    assign bus.if_valid        = (state_q == StHold) && !redir;
    assign bus.if_pc           = if_pc_q;
    assign bus.if_instr        = if_instr_q;
    assign bus.misaligned      = misaligned_q;
    assign bus.fetch_count     = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues expected requests and deliveries,
// a monitor pops and compares them; a small memory model answers accepted requests.
module tb_pc_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } deliv_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   delivered;
    int   cyc;
    int   rsp_extra;

    logic [31:0] exp_req[$];
    deliv_t      exp_del[$];
    int          deliv_cyc[$];

    pc_fetch_unit_if #(.XLEN(32), .ILEN(32), .CNT_WIDTH(4)) bus ();
    pc_fetch_unit_if #(.XLEN(32), .ILEN(32), .CNT_WIDTH(4)) bus2 ();

    pc_fetch_unit #(
        .XLEN(32), .ILEN(32), .INSTR_BYTES(4), .RESET_VECTOR(32'h0000_0000), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    pc_fetch_unit #(
        .XLEN(32), .ILEN(32), .INSTR_BYTES(2), .RESET_VECTOR(32'h0000_0000), .CNT_WIDTH(4)
    ) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h5A5A_0000 ^ (a * 32'd3);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_fetch(input logic [31:0] a);
        deliv_t d;
        d.pc    = a;
        d.instr = word(a);
        exp_req.push_back(a);
        exp_del.push_back(d);
    endtask

    task automatic wait_deliv(input int target);
        int n = 0;
        while (delivered < target && n < 120) begin
            @(negedge clk);
            n++;
        end
        chk("deliv_count", 64'(delivered), 64'(target));
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.if_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_hold", 64'(bus.if_valid), 64'd1);
    endtask

    task automatic wait_inflight();
        int n = 0;
        @(negedge clk);
        while (bus.fetch_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wait", 64'(bus.fetch_req_valid), 64'd0);
    endtask

    // Memory: one outstanding request, response rsp_extra+1 cycles after accept.
    initial begin
        logic        pend;
        logic [31:0] pend_addr;
        int          left;
        pend = 1'b0;
        pend_addr = '0;
        left = 0;
        bus.fetch_rsp_valid = 1'b0;
        bus.fetch_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                pend = 1'b0;
                bus.fetch_rsp_valid = 1'b0;
            end else begin
                if (pend && left == 0) begin
                    bus.fetch_rsp_valid = 1'b1;
                    bus.fetch_rsp_data  = word(pend_addr);
                    pend = 1'b0;
                end else begin
                    bus.fetch_rsp_valid = 1'b0;
                    if (pend) left--;
                end
                if (bus.fetch_req_valid && bus.fetch_req_ready) begin
                    pend      = 1'b1;
                    pend_addr = bus.fetch_req_addr;
                    left      = rsp_extra;
                end
            end
        end
    end

    // Monitor: compares every accepted request and every delivery against the queues.
    initial begin
        deliv_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (bus.fetch_req_valid && bus.fetch_req_ready) begin
                    if (exp_req.size() == 0) begin
                        chk("unexpected_req", 64'(bus.fetch_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        chk("req_addr", 64'(bus.fetch_req_addr), 64'(exp_req.pop_front()));
                    end
                end
                if (bus.if_valid && bus.if_ready) begin
                    delivered++;
                    deliv_cyc.push_back(cyc);
                    if (exp_del.size() == 0) begin
                        chk("unexpected_deliv", 64'(bus.if_pc), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_del.pop_front();
                        chk("if_pc", 64'(bus.if_pc), 64'(e.pc));
                        chk("if_instr", 64'(bus.if_instr), 64'(e.instr));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; delivered = 0; cyc = 0; rsp_extra = 0;
        reset = 1'b1;
        bus.trap_valid = 1'b0; bus.trap_pc = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        bus.fetch_req_ready = 1'b1; bus.if_ready = 1'b0;
        bus2.trap_valid = 1'b0; bus2.trap_pc = '0;
        bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0;
        bus2.fetch_req_ready = 1'b0; bus2.if_ready = 1'b0;
        bus2.fetch_rsp_valid = 1'b0; bus2.fetch_rsp_data = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 64'(bus.fetch_req_valid), 64'd1);
        chk("rst_req_addr", 64'(bus.fetch_req_addr), 64'h0);
        chk("rst_if_valid", 64'(bus.if_valid), 64'd0);
        chk("rst_if_pc", 64'(bus.if_pc), 64'h0);
        chk("rst_if_instr", 64'(bus.if_instr), 64'h0);
        chk("rst_misaligned", 64'(bus.misaligned), 64'd0);
        chk("rst_count", 64'(bus.fetch_count), 64'd0);

        // Sequential fetch 0x0, 0x4, 0x8 at one delivery per three cycles
        push_fetch(32'h0); push_fetch(32'h4); push_fetch(32'h8);
        bus.if_ready = 1'b1;
        reset = 1'b0;
        wait_deliv(3);
        bus.fetch_req_ready = 1'b0;
        chk("count_after_3", 64'(bus.fetch_count), 64'd3);
        chk("addr_after_3", 64'(bus.fetch_req_addr), 64'hC);
        if (deliv_cyc.size() >= 3) begin
            chk("gap_1", 64'(deliv_cyc[1] - deliv_cyc[0]), 64'd3);
            chk("gap_2", 64'(deliv_cyc[2] - deliv_cyc[1]), 64'd3);
        end else begin
            chk("gap_samples", 64'(deliv_cyc.size()), 64'd3);
        end

        // Decode stall: buffer held stable, no new request
        bus.if_ready = 1'b0;
        bus.fetch_req_ready = 1'b1;
        push_fetch(32'hC);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_if_valid", 64'(bus.if_valid), 64'd1);
            chk("stall_if_pc", 64'(bus.if_pc), 64'hC);
            chk("stall_if_instr", 64'(bus.if_instr), 64'(word(32'hC)));
            chk("stall_no_req", 64'(bus.fetch_req_valid), 64'd0);
            chk("stall_count", 64'(bus.fetch_count), 64'd3);
        end
        bus.if_ready = 1'b1;
        wait_deliv(4);
        bus.fetch_req_ready = 1'b0;
        chk("count_after_4", 64'(bus.fetch_count), 64'd4);
        chk("addr_after_4", 64'(bus.fetch_req_addr), 64'h10);

        // Redirect to 0x100 in WAIT, response two cycles after accept is discarded
        rsp_extra = 1;
        bus.fetch_req_ready = 1'b1;
        exp_req.push_back(32'h10);
        wait_inflight();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h100;
        rsp_extra = 0;
        push_fetch(32'h100);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("killwait_req_valid", 64'(bus.fetch_req_valid), 64'd0);
        chk("killwait_if_valid", 64'(bus.if_valid), 64'd0);
        chk("aligned_no_mis", 64'(bus.misaligned), 64'd0);
        @(negedge clk);
        chk("kill_addr", 64'(bus.fetch_req_addr), 64'h100);
        chk("kill_if_valid", 64'(bus.if_valid), 64'd0);
        wait_deliv(5);
        bus.fetch_req_ready = 1'b0;
        chk("count_after_5", 64'(bus.fetch_count), 64'd5);

        // Trap and redirect together with a request accept: trap wins, fetch killed
        bus.fetch_req_ready = 1'b1;
        bus.trap_valid = 1'b1; bus.trap_pc = 32'h80;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
        exp_req.push_back(32'h104);
        push_fetch(32'h80);
        @(negedge clk);
        bus.trap_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("trap_in_wait", 64'(bus.fetch_req_valid), 64'd0);
        @(negedge clk);
        chk("trap_addr", 64'(bus.fetch_req_addr), 64'h80);
        chk("trap_if_valid", 64'(bus.if_valid), 64'd0);
        wait_deliv(6);
        bus.fetch_req_ready = 1'b0;
        chk("count_after_6", 64'(bus.fetch_count), 64'd6);
        chk("addr_after_6", 64'(bus.fetch_req_addr), 64'h84);

        // Misaligned redirect with 4-byte instructions
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h102;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("mis_addr", 64'(bus.fetch_req_addr), 64'h100);
        chk("mis_pulse", 64'(bus.misaligned), 64'd1);
        @(negedge clk);
        chk("mis_pulse_end", 64'(bus.misaligned), 64'd0);

        // Redirect while holding a word: buffer dropped, no count
        bus.fetch_req_ready = 1'b1;
        bus.if_ready = 1'b0;
        exp_req.push_back(32'h100);
        wait_valid();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
        bus.if_ready = 1'b1;
        push_fetch(32'h40);
        #1;
        chk("hold_redir_mask", 64'(bus.if_valid), 64'd0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("hold_redir_addr", 64'(bus.fetch_req_addr), 64'h40);
        chk("hold_redir_count", 64'(bus.fetch_count), 64'd6);
        wait_deliv(7);
        bus.fetch_req_ready = 1'b0;
        chk("count_after_7", 64'(bus.fetch_count), 64'd7);

        // 2-byte instructions: 0x102 is aligned, 0x103 is not
        bus2.redirect_valid = 1'b1; bus2.redirect_pc = 32'h102;
        @(negedge clk);
        chk("ib2_addr_102", 64'(bus2.fetch_req_addr), 64'h102);
        chk("ib2_no_mis", 64'(bus2.misaligned), 64'd0);
        bus2.redirect_pc = 32'h103;
        @(negedge clk);
        bus2.redirect_valid = 1'b0;
        chk("ib2_addr_103", 64'(bus2.fetch_req_addr), 64'h102);
        chk("ib2_mis", 64'(bus2.misaligned), 64'd1);
        @(negedge clk);
        chk("ib2_mis_end", 64'(bus2.misaligned), 64'd0);

        // Asynchronous reset in WAIT, then 17 deliveries wrap the 4-bit counter to 1
        bus.fetch_req_ready = 1'b1;
        exp_req.push_back(32'h44);
        wait_inflight();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req_valid", 64'(bus.fetch_req_valid), 64'd1);
        chk("arst_req_addr", 64'(bus.fetch_req_addr), 64'h0);
        chk("arst_if_valid", 64'(bus.if_valid), 64'd0);
        chk("arst_if_pc", 64'(bus.if_pc), 64'h0);
        chk("arst_if_instr", 64'(bus.if_instr), 64'h0);
        chk("arst_count", 64'(bus.fetch_count), 64'd0);
        chk("arst_misaligned", 64'(bus.misaligned), 64'd0);
        for (int i = 0; i < 17; i++) push_fetch(32'(i * 4));
        bus.if_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_deliv(24);
        bus.fetch_req_ready = 1'b0;
        chk("count_wrap", 64'(bus.fetch_count), 64'd1);
        chk("addr_after_wrap", 64'(bus.fetch_req_addr), 64'h44);

        repeat (3) @(negedge clk);
        chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
        chk("del_queue_empty", 64'(exp_del.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter and instruction-fetch sequencer for the CPU core. It holds the architectural fetch PC and issues one instruction request at a time to instruction memory over a valid/ready handshake. It buffers the returned word for the decode stage and applies trap and branch/jump redirects, including killing an in-flight fetch. It replaces the bare PC register in the pipelined core and keeps a running count of delivered instructions.

## Interface
Parameters:
- XLEN, 32, width of PC and addresses
- ILEN, 32, instruction word width
- INSTR_BYTES, 4, sequential PC increment and alignment (legal: 2, 4)
- RESET_VECTOR, 32'h0000_0000, PC value after reset
- CNT_WIDTH, 32, width of delivered-instruction counter

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- trap_valid  in  1  trap/exception redirect request, highest priority
- trap_pc  in  XLEN  trap handler target
- redirect_valid  in  1  branch/jump redirect from EX
- redirect_pc  in  XLEN  branch/jump target
- fetch_req_valid  out  1  request to instruction memory
- fetch_req_addr  out  XLEN  request address
- fetch_req_ready  in  1  memory accepts request
- fetch_rsp_valid  in  1  response word present (one-cycle pulse per accepted request)
- fetch_rsp_data  in  ILEN  instruction word
- if_valid  out  1  buffered instruction available to decode
- if_pc  out  XLEN  PC of buffered instruction
- if_instr  out  ILEN  buffered instruction
- if_ready  in  1  decode consumes instruction
- misaligned  out  1  one-cycle pulse: redirect target not INSTR_BYTES-aligned
- fetch_count  out  CNT_WIDTH  instructions delivered (if_valid && if_ready, not killed)

## Operation
- States: REQ (fetch_req_valid=1, addr=pc), WAIT (request accepted, awaiting response), HOLD (word buffered, if_valid=1).
- REQ: on fetch_req_valid && fetch_req_ready -> WAIT; the request address is latched as if_pc.
- WAIT: on fetch_rsp_valid -> load if_instr, pc <= if_pc + INSTR_BYTES (mod 2^XLEN), -> HOLD. If kill flag set: discard the word, clear kill, -> REQ, pc unchanged.
- HOLD: on if_ready -> REQ, fetch_count += 1 (wraps at 2^CNT_WIDTH).
- Redirect source: trap_valid wins over redirect_valid. The target is loaded into pc, aligned down (low log2(INSTR_BYTES) bits cleared). If the unaligned target differs from the aligned one, misaligned pulses the next cycle.
- Redirect in REQ without accept: pc <= target, stay REQ.
- Redirect in REQ with accept the same cycle: -> WAIT with kill=1, pc <= target.
- Redirect in WAIT: kill=1, pc <= target. If fetch_rsp_valid arrives the same cycle, the word is discarded and the unit goes -> REQ.
- Redirect in HOLD: buffer dropped, -> REQ, pc <= target.
- if_valid is forced 0 combinationally while trap_valid or redirect_valid is high. fetch_count does not increment in that cycle.
- fetch_rsp_valid in REQ or HOLD is ignored.
- fetch_req_addr is always the registered pc and is stable while fetch_req_valid=1 and no redirect occurs.

## Timing
- Reset values: state=REQ, pc=RESET_VECTOR, fetch_req_valid=1, fetch_req_addr=RESET_VECTOR, if_valid=0, if_pc=0, if_instr=0, kill=0, misaligned=0, fetch_count=0.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Instruction memory shares the same reset, so there are no stale responses.
- Latency: a request accepted at cycle N with the response at N+1 gives if_valid at N+2. With if_ready high, the next request is issued at N+3.
- Peak throughput: one instruction per 3 cycles with zero-wait memory.
- A redirect at cycle N gives fetch_req_addr = target at cycle N+1.
- misaligned is registered, asserted exactly at N+1 for one cycle.
- fetch_count updates on the edge where the handshake completes.

## Test plan
- Reset release, memory always ready, 1-cycle response -> requests at 0x0, 0x4, 0x8. if_pc and if_instr match memory, with one delivery per 3 cycles. fetch_count = 3 after three handshakes.
- if_ready held low for 5 cycles in HOLD -> if_valid, if_pc and if_instr stable, no new request, fetch_count unchanged.
- Redirect to 0x100 while in WAIT, response 2 cycles later -> response discarded, if_valid stays 0, next request address = 0x100.
- trap_valid (trap_pc=0x80) and redirect_valid (0x200) in the same cycle as a request accept -> kill set, next request address = 0x80.
- Redirect to 0x102 with INSTR_BYTES=4 -> next request address = 0x100, misaligned high for exactly one cycle. With INSTR_BYTES=2 -> address 0x102, no misaligned pulse.
- Asynchronous reset pulse mid-WAIT and counter wrap (CNT_WIDTH=4, 17 deliveries): outputs immediately return to reset values, the first request goes to RESET_VECTOR, and fetch_count wraps to 1.
